// File: rtl/mvm_pkg.sv
// mvm_pkg: shared definitions for the matrix-vector stream engine.
//   state_t    : engine FSM states (IDLE, COMPUTE, DONE)
//   clog2      : ceiling log2, usable in constant expressions
//   sat_signed : clamps a 64-bit signed value to a signed range of 'bits' bits
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mvm_row_dot.sv
// mvm_row_dot: combinational dot product of one input vector with one weight row.
// Ports:
//   vec : VEC_LEN signed elements of IN_BITS
//   wts : VEC_LEN signed weights of W_BITS
//   dot : signed sum of the full-precision products, ACC_BITS wide
module mvm_row_dot #(
  parameter int VEC_LEN  = 4,
  parameter int IN_BITS  = 4,
  parameter int W_BITS   = 4,
  parameter int ACC_BITS = 12
) (
  input  logic signed [IN_BITS-1:0]  vec [VEC_LEN],
  input  logic signed [W_BITS-1:0]   wts [VEC_LEN],
  output logic signed [ACC_BITS-1:0] dot
);

  localparam int PROD_W = IN_BITS + W_BITS;

  logic signed [PROD_W-1:0] prod [VEC_LEN];

  always_comb begin
    dot = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      // Widen both operands first so the product keeps full precision.
      prod[i] = PROD_W'(vec[i]) * PROD_W'(wts[i]);
      dot     = dot + ACC_BITS'(prod[i]);
    end
  end

endmodule

// File: rtl/mat_vec_stream_engine.sv
// mat_vec_stream_engine: multiplies NUM_ENG captured vectors by an MAT_R x VEC_LEN
// signed weight matrix, one matrix row per cycle, with optional accumulation
// into the previous result set.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     : transaction handshake (ready only in IDLE)
//   in_vecs, acc_mode     : input vectors and accumulate select, captured on accept
//   mat_wr_en/row/data    : weight row write (ignored while computing)
//   out_valid/out_ready   : result handshake, results held until taken
//   out_vecs, sat_flag    : saturated results and "some output clamped" flag
//   busy                  : engine is not IDLE
module mat_vec_stream_engine
  import mvm_pkg::*;
#(
  parameter int NUM_ENG  = 2,
  parameter int VEC_LEN  = 4,
  parameter int MAT_R    = 8,
  parameter int IN_BITS  = 4,
  parameter int W_BITS   = 4,
  parameter int ACC_BITS = 12,  // must be >= IN_BITS+W_BITS+clog2(VEC_LEN)
  parameter int OUT_BITS = 8,
  parameter int SHIFT    = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_BITS-1:0]   in_vecs [NUM_ENG][VEC_LEN],
  input  logic                        acc_mode,
  input  logic                        mat_wr_en,
  input  logic [clog2(MAT_R)-1:0]     mat_wr_row,
  input  logic signed [W_BITS-1:0]    mat_wr_data [VEC_LEN],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_BITS-1:0]  out_vecs [NUM_ENG][MAT_R],
  output logic                        sat_flag,
  output logic                        busy
);

  localparam int ROW_W = clog2(MAT_R);

  state_t                      state;
  logic [ROW_W-1:0]            row;
  logic signed [IN_BITS-1:0]   vec_p0 [NUM_ENG][VEC_LEN];
  logic                        mode_p0;
  logic signed [W_BITS-1:0]    wmem [MAT_R][VEC_LEN];
  logic signed [ACC_BITS-1:0]  acc [NUM_ENG][MAT_R];

  logic signed [W_BITS-1:0]    row_w [VEC_LEN];
  logic signed [ACC_BITS-1:0]  dot [NUM_ENG];
  logic signed [ACC_BITS-1:0]  acc_nxt [NUM_ENG];
  logic signed [ACC_BITS-1:0]  shf [NUM_ENG];
  logic signed [OUT_BITS-1:0]  out_nxt [NUM_ENG];
  logic [NUM_ENG-1:0]          clamp;

  assign in_ready = (state == IDLE);

  // Stage p0 -> row compute: weight row selected by the row counter
  always_comb begin
    for (int c = 0; c < VEC_LEN; c++) row_w[c] = wmem[row][c];
  end

  for (genvar e = 0; e < NUM_ENG; e++) begin : g_eng
    mvm_row_dot #(
      .VEC_LEN (VEC_LEN),
      .IN_BITS (IN_BITS),
      .W_BITS  (W_BITS),
      .ACC_BITS(ACC_BITS)
    ) u_dot (
      .vec(vec_p0[e]),
      .wts(row_w),
      .dot(dot[e])
    );
  end

  always_comb begin
    for (int e = 0; e < NUM_ENG; e++) begin
      acc_nxt[e] = dot[e];
      if (mode_p0)
        acc_nxt[e] = ACC_BITS'(sat_signed(64'(acc[e][row]) + 64'(dot[e]), ACC_BITS));
      shf[e]     = acc_nxt[e] >>> SHIFT;
      out_nxt[e] = OUT_BITS'(sat_signed(64'(shf[e]), OUT_BITS));
      clamp[e]   = (sat_signed(64'(shf[e]), OUT_BITS) != 64'(shf[e]));
    end
  end

  // Row compute -> registered accumulators / outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= '0;
      mode_p0   <= 1'b0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      busy      <= 1'b0;
      for (int e = 0; e < NUM_ENG; e++) begin
        for (int c = 0; c < VEC_LEN; c++) vec_p0[e][c] <= '0;
        for (int r = 0; r < MAT_R; r++) begin
          acc[e][r]      <= '0;
          out_vecs[e][r] <= '0;
        end
      end
      for (int r = 0; r < MAT_R; r++)
        for (int c = 0; c < VEC_LEN; c++) wmem[r][c] <= '0;
    end else begin
      // A write landing on the accept edge is seen by row 0 one cycle later.
      if (mat_wr_en && state != COMPUTE)
        for (int c = 0; c < VEC_LEN; c++) wmem[mat_wr_row][c] <= mat_wr_data[c];

      case (state)
        IDLE: begin
          if (in_valid) begin
            vec_p0   <= in_vecs;
            mode_p0  <= acc_mode;
            row      <= '0;
            sat_flag <= 1'b0;
            busy     <= 1'b1;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int e = 0; e < NUM_ENG; e++) begin
            acc[e][row]      <= acc_nxt[e];
            out_vecs[e][row] <= out_nxt[e];
          end
          sat_flag <= sat_flag | (|clamp);
          row      <= row + 1'b1;
          if (row == ROW_W'(MAT_R - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_stream_engine.sv
// Directed bench for mat_vec_stream_engine at default parameters.
module tb_mat_vec_stream_engine;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [3:0] in_vecs [2][4];
  logic              acc_mode = 1'b0;
  logic              mat_wr_en = 1'b0;
  logic [2:0]        mat_wr_row = '0;
  logic signed [3:0] mat_wr_data [4];
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] out_vecs [2][8];
  logic              sat_flag;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mat_vec_stream_engine dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vecs    (in_vecs),
    .acc_mode   (acc_mode),
    .mat_wr_en  (mat_wr_en),
    .mat_wr_row (mat_wr_row),
    .mat_wr_data(mat_wr_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vecs   (out_vecs),
    .sat_flag   (sat_flag),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wdata(input int w0, input int w1, input int w2, input int w3);
    mat_wr_data[0] = 4'(w0);
    mat_wr_data[1] = 4'(w1);
    mat_wr_data[2] = 4'(w2);
    mat_wr_data[3] = 4'(w3);
  endtask

  task automatic wr_row(input int r, input int w0, input int w1, input int w2, input int w3);
    mat_wr_en  = 1'b1;
    mat_wr_row = 3'(r);
    set_wdata(w0, w1, w2, w3);
    tick();
    mat_wr_en = 1'b0;
  endtask

  task automatic load_identity();
    for (int r = 0; r < 8; r++)
      wr_row(r, int'(r % 4 == 0), int'(r % 4 == 1), int'(r % 4 == 2), int'(r % 4 == 3));
  endtask

  task automatic set_vecs(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    in_vecs[0][0] = 4'(a0); in_vecs[0][1] = 4'(a1);
    in_vecs[0][2] = 4'(a2); in_vecs[0][3] = 4'(a3);
    in_vecs[1][0] = 4'(b0); in_vecs[1][1] = 4'(b1);
    in_vecs[1][2] = 4'(b2); in_vecs[1][3] = 4'(b3);
  endtask

  // Accept one transaction and wait (bounded) for out_valid; leaves the DUT in DONE.
  task automatic run(input string tag, input logic mode, input bit mid_wr, input bit co_wr);
    int k;
    bit seen;
    in_valid = 1'b1;
    acc_mode = mode;
    if (co_wr) begin
      mat_wr_en  = 1'b1;
      mat_wr_row = 3'd1;
      set_wdata(2, 0, 0, 0);
    end
    tick();
    in_valid  = 1'b0;
    acc_mode  = 1'b0;
    mat_wr_en = 1'b0;
    check({tag, ".busy"}, busy, 1);
    check({tag, ".in_ready_busy"}, in_ready, 0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      if (mid_wr && k == 1) begin
        mat_wr_en  = 1'b1;
        mat_wr_row = 3'd0;
        set_wdata(7, 7, 7, 7);
      end
      tick();
      mat_wr_en = 1'b0;
      k++;
      seen = out_valid;
    end
    check({tag, ".latency"}, k, 8);
  endtask

  task automatic check_outs(input string tag, input int x0 [8], input int x1 [8]);
    for (int r = 0; r < 8; r++) begin
      check($sformatf("%s.e0r%0d", tag, r), out_vecs[0][r], x0[r]);
      check($sformatf("%s.e1r%0d", tag, r), out_vecs[1][r], x1[r]);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle_ready"}, in_ready, 1);
    check({tag, ".valid_drop"}, out_valid, 0);
    check({tag, ".busy_drop"}, busy, 0);
  endtask

  initial begin
    int x0 [8];
    int x1 [8];
    int nz;
    bit pulse;

    set_vecs(0, 0, 0, 0, 0, 0, 0, 0);
    set_wdata(0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.sat", sat_flag, 0);
    check("rst.out_e1r7", out_vecs[1][7], 0);
    reset = 1'b1;
    tick();

    // Identity matrix
    load_identity();
    set_vecs(1, 2, 3, 4, -1, -2, -3, -4);
    run("id", 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin x0[r] = (r % 4) + 1; x1[r] = -((r % 4) + 1); end
    check_outs("id", x0, x1);
    check("id.sat", sat_flag, 0);
    release_out("id");

    // Accumulate onto the identity result, then backpressure in DONE
    run("acc", 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin x0[r] = 2 * ((r % 4) + 1); x1[r] = -2 * ((r % 4) + 1); end
    check_outs("acc", x0, x1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.e0r3", out_vecs[0][3], 8);
      check("bp.e1r4", out_vecs[1][4], -2);
      check("bp.in_ready", in_ready, 0);
      check("bp.valid", out_valid, 1);
    end
    release_out("bp");

    // Saturation: 4 * (-8 * -8) = 256 clamps to 127
    for (int r = 0; r < 8; r++) wr_row(r, -8, -8, -8, -8);
    set_vecs(-8, -8, -8, -8, -8, -8, -8, -8);
    run("sat", 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin x0[r] = 127; x1[r] = 127; end
    check_outs("sat", x0, x1);
    check("sat.flag", sat_flag, 1);
    release_out("sat");

    // Write to row 0 during COMPUTE is dropped for this and the next result
    load_identity();
    set_vecs(1, 2, 3, 4, -1, -2, -3, -4);
    run("wc1", 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin x0[r] = (r % 4) + 1; x1[r] = -((r % 4) + 1); end
    check_outs("wc1", x0, x1);
    check("wc1.sat", sat_flag, 0);
    release_out("wc1");
    run("wc2", 1'b0, 1'b0, 1'b0);
    check_outs("wc2", x0, x1);
    release_out("wc2");

    // Write coincident with accept: row 1 = {2,0,0,0} is used immediately
    run("co", 1'b0, 1'b0, 1'b1);
    x0[1] = 2;
    x1[1] = -2;
    check_outs("co", x0, x1);
    release_out("co");

    // Reset during row 3 of COMPUTE
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    nz = 0;
    for (int e = 0; e < 2; e++)
      for (int r = 0; r < 8; r++)
        if (out_vecs[e][r] != 0) nz++;
    check("mr.out_nonzero", nz, 0);
    check("mr.in_ready", in_ready, 1);
    check("mr.valid", out_valid, 0);
    check("mr.busy", busy, 0);
    check("mr.sat", sat_flag, 0);
    tick();
    reset = 1'b1;
    pulse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) pulse = 1'b1;
    end
    check("mr.no_pulse", pulse, 0);

    // Weights were cleared by reset
    set_vecs(1, 2, 3, 4, -1, -2, -3, -4);
    run("zw", 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin x0[r] = 0; x1[r] = 0; end
    check_outs("zw", x0, x1);
    release_out("zw");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mat_vec_stream_engine.md
MAT_VEC_STREAM_ENGINE -- requirements
Module: mat_vec_stream_engine

Interface
REQ-001 Parameters SHALL be:
- NUM_ENG, 2, number of parallel input vectors.
- VEC_LEN, 4, vector length and matrix columns.
- MAT_R, 8, matrix rows.
- IN_BITS, 4, signed vector element width.
- W_BITS, 4, signed weight width.
- ACC_BITS, 12, signed accumulator width; SHALL satisfy ACC_BITS >= IN_BITS+W_BITS+clog2(VEC_LEN).
- OUT_BITS, 8, signed output width.
- SHIFT, 0, arithmetic right shift applied before output saturation.

REQ-002 Ports SHALL be:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction offered.
- in_ready  out  1  engine can accept a transaction.
- in_vecs  in  [NUM_ENG][VEC_LEN] x IN_BITS  signed input vectors.
- acc_mode  in  1  sampled with in_vecs; 1 = add to previous accumulators.
- mat_wr_en  in  1  weight-row write strobe.
- mat_wr_row  in  clog2(MAT_R)  row index to write.
- mat_wr_data  in  [VEC_LEN] x W_BITS  signed weight row.
- out_valid  out  1  results available.
- out_ready  in  1  consumer takes results.
- out_vecs  out  [NUM_ENG][MAT_R] x OUT_BITS  signed results.
- sat_flag  out  1  an output of the current result set saturated.
- busy  out  1  state is not IDLE.

Function
REQ-003 FSM SHALL have states IDLE, COMPUTE and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE.
REQ-005 In IDLE, in_valid&&in_ready SHALL capture in_vecs and acc_mode, clear row counter and sat_flag, and enter COMPUTE.
REQ-006 In COMPUTE, row r SHALL be computed for all NUM_ENG engines in one cycle and registered at the edge ending that cycle.
REQ-007 The row counter SHALL increment each COMPUTE cycle; the edge that registers row MAT_R-1 SHALL enter DONE.
REQ-008 Latency: for a transaction accepted at edge e0, out_valid SHALL be 1 starting after edge e0+MAT_R.
REQ-009 In DONE, out_vecs, sat_flag and out_valid SHALL be held until out_ready=1; that edge SHALL enter IDLE. There SHALL be no same-cycle accept in DONE.
REQ-010 Dot product: each product SHALL be IN_BITS+W_BITS bits, full precision, and summed at ACC_BITS width.
REQ-011 acc_mode=0: acc[e][r] = dot. acc_mode=1: acc[e][r] = acc[e][r] + dot, saturated to ACC_BITS.
REQ-012 out_vecs[e][r] SHALL equal acc[e][r] >>> SHIFT, saturated to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]. Any clamp SHALL set sat_flag.
REQ-013 Weight writes SHALL be applied in IDLE and DONE and ignored in COMPUTE.
REQ-014 A write coincident with an IDLE accept SHALL be applied and SHALL be visible to that transaction.
REQ-015 out_valid and busy SHALL be registered outputs with no combinational path from inputs. in_ready SHALL be decoded from state only.

Reset
REQ-016 reset=0 SHALL asynchronously force IDLE and zero all of the following: row counter, accumulators, weight storage, out_vecs, out_valid, sat_flag, busy.
REQ-017 After reset, in_ready SHALL be 1.
REQ-018 Reset in any state, including mid-COMPUTE, SHALL abandon the transaction with no out_valid pulse.

Structure
REQ-019 Package mvm_pkg SHALL hold the state enum, the clog2 helper and the signed saturate function.
REQ-020 Sub-module mvm_row_dot SHALL compute one VEC_LEN dot product and SHALL be instantiated NUM_ENG times.
REQ-021 The target size is 120-400 lines of RTL.

Verification (default parameters)
REQ-022 Identity load: row r weight 1 at column r%4, else 0.
- Stimulus: eng0={1,2,3,4}, eng1={-1,-2,-3,-4}.
- Required: out_vecs[0][r]=(r%4)+1 and out_vecs[1][r]=-((r%4)+1); out_valid 8 cycles after accept; sat_flag=0.
REQ-023 Saturation: all weights -8, all inputs -8.
- Required: acc=256; outputs=127; sat_flag=1.
REQ-024 Accumulate: run the REQ-022 case, then repeat it with acc_mode=1.
- Required: eng0 row r = 2*((r%4)+1).
REQ-025 Backpressure: hold out_ready=0 for 5 cycles in DONE.
- Required: outputs stable and in_ready=0 throughout.
- Then out_ready=1: IDLE and in_ready=1 on the next cycle.
REQ-026 Write during COMPUTE: write row 0 to all 7s.
- Required: the current and the next result both use the old weights.
REQ-027 Reset at row 3 of COMPUTE.
- Required: all outputs 0 and in_ready=1; out_valid never asserted.
- Next transaction with unloaded weights: outputs all 0.
